stream_load_ctrl: RTL and testbench

- Parametrised successor to the UART load controller.
- Sits between the UART receiver (rx_ready/rx_byte) and the matrix-storage memory write port.
- Parses a length-prefixed byte stream, packs bytes little-endian into DATA_W words and writes them through a valid/ready handshake with an auto-incrementing write pointer.
- Adds a stream timeout, overrun/length error detection and a sequential readback pointer.

---
 rtl/comm_pkg.sv | 32 +++
 rtl/stream_load_ctrl_if.sv | 43 ++++
 rtl/comm_byte_skid.sv | 46 ++++
 rtl/stream_load_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_stream_load_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the stream load path
//
// Contents:
//   LEN_W        width of the length header carried in front of the payload
//   state_e      controller states
//   err_flags_t  sticky error flags reported by the controller
//   make_len     assembles the little-endian length header
package comm_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_e;

  typedef struct packed {
    logic len;  // header length larger than the memory
    logic ovr;  // byte lost while the skid was already occupied
    logic tmo;  // inter-byte gap reached the timeout
  } err_flags_t;

  function automatic logic [LEN_W-1:0] make_len(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/stream_load_ctrl_if.sv
// rtl/stream_load_ctrl_if.sv - receive-byte and memory-write signal bundle
//
// Signals:
//   rx_ready   one-cycle strobe, rx_byte valid
//   rx_byte    received byte
//   wr_valid   write request towards memory
//   wr_ready   memory accepts the write when high together with wr_valid
//   write_ptr  address of the current/next write
//   wdata      packed little-endian word
// Modports:
//   master     the load controller
//   slave      UART receiver plus memory side
interface stream_load_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              rx_ready;
  logic [7:0]        rx_byte;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] write_ptr;
  logic [DATA_W-1:0] wdata;

  modport master (
    input  rx_ready,
    input  rx_byte,
    input  wr_ready,
    output wr_valid,
    output write_ptr,
    output wdata
  );

  modport slave (
    output rx_ready,
    output rx_byte,
    output wr_ready,
    input  wr_valid,
    input  write_ptr,
    input  wdata
  );

endinterface

// File: rtl/comm_byte_skid.sv
// rtl/comm_byte_skid.sv - one-entry byte holding register with overrun detect
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       synchronous flush of the entry
//   push, din   store a byte
//   pop         release the stored byte (dout valid while full)
//   dout        stored byte
//   full        entry occupied
//   overrun     push while full without a simultaneous pop; the byte is dropped
module comm_byte_skid (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       overrun
);

  logic [7:0] data_q;
  logic       full_q;

  assign dout    = data_q;
  assign full    = full_q;
  assign overrun = push && full_q && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clear) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (push && (!full_q || pop)) begin
      // Push with a simultaneous pop replaces the entry and keeps it occupied.
      data_q <= din;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_load_ctrl.sv
// rtl/stream_load_ctrl.sv - length-prefixed byte stream to memory word loader
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          rx byte strobe in, memory write handshake out (master modport)
//   load_data    level; high arms/continues a load, low returns to IDLE
//   rd_next      pulse; advances read_ptr while DONE
//   read_ptr     sequential readback address
//   busy         loading (LEN_LO, LEN_HI, PAYLOAD, WRITE)
//   done         load complete
//   err_len      sticky; header length larger than DEPTH
//   err_ovr      sticky; byte lost because the skid was full
//   err_tmo      sticky; inter-byte timeout
module stream_load_ctrl
  import comm_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 65536,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_load_ctrl_if.master   bus,
  input  logic                 load_data,
  input  logic                 rd_next,
  output logic [ADDR_W-1:0]    read_ptr,
  output logic                 busy,
  output logic                 done,
  output logic                 err_len,
  output logic                 err_ovr,
  output logic                 err_tmo
);

  localparam int DATA_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_LEN_LO  = LEN_LO;
  localparam logic [2:0] S_LEN_HI  = LEN_HI;
  localparam logic [2:0] S_PAYLOAD = PAYLOAD;
  localparam logic [2:0] S_WRITE   = WRITE;
  localparam logic [2:0] S_DONE    = DONE;
  localparam logic [2:0] S_ERROR   = ERROR;

  logic [2:0]        state;
  logic [7:0]        len_lo;
  logic [LEN_W-1:0]  words_left;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] write_ptr_q;
  logic [ADDR_W-1:0] read_ptr_q;
  logic [DATA_W-1:0] wdata_q;
  err_flags_t        err;

  logic              skid_full;
  logic              skid_ovr;
  logic [7:0]        skid_dout;
  logic              skid_push;
  logic              skid_pop;
  logic              skid_clear;

  logic              wr_fire;
  logic              have_byte;
  logic [7:0]        cur_byte;
  logic [LEN_W-1:0]  hdr_len;
  logic              tmo_active;
  logic              tmo_hit;
  logic [ADDR_W-1:0] rd_inc;

  // wr_valid is combinational on load_data so an abort withdraws the request
  // in the same cycle instead of one clock later.
  assign bus.wr_valid  = (state == S_WRITE) && load_data;
  assign bus.write_ptr = write_ptr_q;
  assign bus.wdata     = wdata_q;

  assign read_ptr = read_ptr_q;
  assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_PAYLOAD) || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err_len  = err.len;
  assign err_ovr  = err.ovr;
  assign err_tmo  = err.tmo;

  assign wr_fire = bus.wr_valid && bus.wr_ready;

  // Bytes that arrive while a word is waiting to be written are parked in the
  // skid. Back in PAYLOAD the parked byte is consumed first; a byte arriving
  // in that same cycle takes its place in the skid.
  assign skid_pop   = (state == S_PAYLOAD) && load_data && skid_full;
  assign skid_push  = load_data && bus.rx_ready &&
                      ((state == S_WRITE) || ((state == S_PAYLOAD) && skid_full));
  assign skid_clear = (state == S_IDLE);

  assign have_byte = (state == S_PAYLOAD) && (skid_full || bus.rx_ready);
  assign cur_byte  = skid_full ? skid_dout : bus.rx_byte;
  assign hdr_len   = make_len(len_lo, bus.rx_byte);

  // The byte strobe and the write handshake both restart the gap count, so
  // an expiry coinciding with either of them is suppressed.
  assign tmo_active = (state == S_LEN_HI) || (state == S_PAYLOAD) || (state == S_WRITE);
  assign tmo_hit    = tmo_active && !bus.rx_ready && !wr_fire && (tmo_cnt == TMO_LAST);

  assign rd_inc = read_ptr_q + 1'b1;

  comm_byte_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear   (skid_clear),
    .push    (skid_push),
    .pop     (skid_pop),
    .din     (bus.rx_byte),
    .dout    (skid_dout),
    .full    (skid_full),
    .overrun (skid_ovr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      len_lo      <= '0;
      words_left  <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      write_ptr_q <= '0;
      read_ptr_q  <= '0;
      wdata_q     <= '0;
      err         <= '0;
    end else if ((state != S_IDLE) && !load_data) begin
      // Abort: pointers, data and error flags stay readable until the next arm.
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      if (!tmo_active || bus.rx_ready || wr_fire) begin
        tmo_cnt <= '0;
      end else if (!tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (load_data) begin
            state       <= S_LEN_LO;
            write_ptr_q <= '0;
            read_ptr_q  <= '0;
            byte_cnt    <= '0;
            words_left  <= '0;
            err         <= '0;
          end
        end

        S_LEN_LO: begin
          if (bus.rx_ready) begin
            len_lo <= bus.rx_byte;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (bus.rx_ready) begin
            if (hdr_len == '0) begin
              state <= S_DONE;
            end else if (32'(hdr_len) > 32'(DEPTH)) begin
              state   <= S_ERROR;
              err.len <= 1'b1;
            end else begin
              words_left <= hdr_len;
              byte_cnt   <= '0;
              state      <= S_PAYLOAD;
            end
          end else if (tmo_hit) begin
            state   <= S_ERROR;
            err.tmo <= 1'b1;
          end
        end

        S_PAYLOAD: begin
          if (have_byte) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
              if (byte_cnt == CNT_W'(k)) begin
                wdata_q[8*k +: 8] <= cur_byte;
              end
            end
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              state <= S_WRITE;
            end
          end else if (tmo_hit) begin
            state   <= S_ERROR;
            err.tmo <= 1'b1;
          end
        end

        S_WRITE: begin
          // A handshake seen on the bus always advances the pointer, even if
          // an overrun in the same cycle ends the load.
          if (wr_fire) begin
            write_ptr_q <= write_ptr_q + 1'b1;
            words_left  <= words_left - 1'b1;
            byte_cnt    <= '0;
          end
          if (skid_ovr) begin
            state   <= S_ERROR;
            err.ovr <= 1'b1;
          end else if (wr_fire) begin
            state <= (words_left == LEN_W'(1)) ? S_DONE : S_PAYLOAD;
          end else if (tmo_hit) begin
            state   <= S_ERROR;
            err.tmo <= 1'b1;
          end
        end

        S_DONE: begin
          // Readback walks 0 .. write_ptr-1 and wraps; nothing to walk when
          // no word was written (or the pointer wrapped to zero).
          if (rd_next && (write_ptr_q != '0)) begin
            read_ptr_q <= (rd_inc == write_ptr_q) ? '0 : rd_inc;
          end
        end

        S_ERROR: begin
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_load_ctrl.sv
// tb/tb_stream_load_ctrl.sv - scoreboard bench for the stream load controller
module tb_stream_load_ctrl;

  localparam int BPW    = 2;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int TMO    = 50;
  localparam int DATA_W = 8 * BPW;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_data;
  logic              rd_next;
  logic [ADDR_W-1:0] read_ptr;
  logic              busy;
  logic              done;
  logic              err_len;
  logic              err_ovr;
  logic              err_tmo;

  int   n_cmp       = 0;
  int   n_bad       = 0;
  int   writes_seen = 0;
  int   wr_mode     = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] pay [0:63];

  always #5 clk = ~clk;

  stream_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stream_load_ctrl #(
    .BYTES_PER_WORD (BPW),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .load_data (load_data),
    .rd_next   (rd_next),
    .read_ptr  (read_ptr),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len),
    .err_ovr   (err_ovr),
    .err_tmo   (err_tmo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int gmax);
    repeat ($urandom_range(0, gmax)) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rx_byte  = b;
    step();
    bus.rx_ready = 1'b0;
  endtask

  task automatic arm();
    load_data = 1'b0;
    step();
    load_data = 1'b1;
    step();
  endtask

  // Memory side: wr_ready policy (always / random / stalled), changed after each edge.
  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wr_mode == 0)      bus.wr_ready = 1'b1;
      else if (wr_mode == 1) bus.wr_ready = 1'($urandom_range(0, 1));
      else                   bus.wr_ready = 1'b0;
    end
  end

  // Monitor: every handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.wr_valid && bus.wr_ready) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got 0x%0h at 0x%0h, want no write", bus.wdata, bus.write_ptr);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.write_ptr), 64'(mon_e.addr));
        check("wr_data", 64'(bus.wdata), 64'(mon_e.data));
      end
    end
  end

  // One complete load of L words taken from pay[]; the model is the stream
  // rule itself: word i goes to address i, byte k of the word in bits 8k+7:8k.
  task automatic run_stream(input int L, input int gmax, input int n_rd);
    int          base;
    int          sent;
    int          guard;
    logic [15:0] l16;
    wr_t         e;
    l16 = 16'(L);
    arm();
    base = writes_seen;
    if (L <= DEPTH) begin
      for (int i = 0; i < L; i++) begin
        e.addr = ADDR_W'(i);
        e.data = '0;
        for (int k = 0; k < BPW; k++) e.data[8*k +: 8] = pay[i*BPW+k];
        exp_q.push_back(e);
      end
    end
    gap(gmax);
    send_byte(l16[7:0]);
    gap(gmax);
    send_byte(l16[15:8]);
    if (L > DEPTH) begin
      step();
      check("len_err", 64'(err_len), 1);
      check("len_busy", 64'(busy), 0);
      check("len_done", 64'(done), 0);
      check("len_wr_valid", 64'(bus.wr_valid), 0);
    end else begin
      sent = 0;
      for (int i = 0; i < L * BPW; i++) begin
        // At most one pending word plus one parked byte may be outstanding.
        guard = 0;
        while (((sent - BPW * (writes_seen - base)) > BPW) && (guard < 200)) begin
          step();
          guard++;
        end
        if (guard >= 200) fail_bound("flow_wait");
        gap(gmax);
        send_byte(pay[i]);
        sent++;
      end
      guard = 0;
      while (!done && (guard < 200)) begin
        step();
        guard++;
      end
      check("done", 64'(done), 1);
      check("write_ptr", 64'(bus.write_ptr), 64'(l16));
      check("errs_clear", 64'({err_len, err_ovr, err_tmo}), 0);
      check("busy_in_done", 64'(busy), 0);
      check("exp_q_drained", 64'(exp_q.size()), 0);
      for (int k = 1; k <= n_rd; k++) begin
        rd_next = 1'b1;
        step();
        rd_next = 1'b0;
        check("read_ptr", 64'(read_ptr), (L == 0) ? 64'd0 : 64'(k % L));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset        = 1'b1;
    load_data    = 1'b0;
    rd_next      = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_byte  = 8'h00;
    repeat (3) step();
    check("rst_wr_valid", 64'(bus.wr_valid), 0);
    check("rst_write_ptr", 64'(bus.write_ptr), 0);
    check("rst_wdata", 64'(bus.wdata), 0);
    check("rst_read_ptr", 64'(read_ptr), 0);
    check("rst_busy_done", 64'({busy, done}), 0);
    check("rst_errs", 64'({err_len, err_ovr, err_tmo}), 0);
    reset = 1'b0;
    step();

    // Three words 0x2211, 0x4433, 0x6655 then readback 1, 2, 0, 1.
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'h11 * (i + 1));
    run_stream(3, 2, 4);

    // Empty stream: straight to DONE, readback stays at 0.
    run_stream(0, 1, 1);

    // Oversized header, then re-arm clears the sticky flags.
    run_stream(5, 1, 0);
    arm();
    check("rearm_err_len", 64'(err_len), 0);
    check("rearm_busy", 64'(busy), 1);

    // Overrun: memory stalled, one byte parked, the next one is lost.
    arm();
    wr_mode = 2;
    step();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    step();
    send_byte(8'hBB);
    step();
    step();
    check("ovr_pending_valid", 64'(bus.wr_valid), 1);
    check("ovr_pending_data", 64'(bus.wdata), 64'h0000_BBAA);
    check("ovr_pending_ptr", 64'(bus.write_ptr), 0);
    send_byte(8'hCC);
    repeat (5) step();
    check("ovr_skid_no_err", 64'(err_ovr), 0);
    send_byte(8'hDD);
    check("ovr_err", 64'(err_ovr), 1);
    check("ovr_wr_valid", 64'(bus.wr_valid), 0);
    check("ovr_write_ptr", 64'(bus.write_ptr), 0);
    check("ovr_busy", 64'(busy), 0);
    repeat (10) step();
    check("ovr_still_idle_bus", 64'(bus.wr_valid), 0);
    wr_mode = 0;

    // Abort while a write is pending: request withdrawn without a clock edge.
    arm();
    wr_mode = 2;
    step();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    step();
    check("abort_valid_before", 64'(bus.wr_valid), 1);
    load_data = 1'b0;
    #1;
    check("abort_valid_comb", 64'(bus.wr_valid), 0);
    step();
    check("abort_busy", 64'(busy), 0);
    check("abort_write_ptr", 64'(bus.write_ptr), 0);
    wr_mode = 0;
    step();

    // Timeout: exactly TMO cycles after the last strobe.
    arm();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    k = 0;
    while (!err_tmo && (k < 100)) begin
      step();
      k++;
    end
    check("tmo_cycles", 64'(k), 64'(TMO));
    check("tmo_err", 64'(err_tmo), 1);
    check("tmo_wr_valid", 64'(bus.wr_valid), 0);
    check("tmo_write_ptr", 64'(bus.write_ptr), 0);

    // Randomised loads with a randomly stalling memory.
    wr_mode = 1;
    for (int t = 0; t < 12; t++) begin
      int L;
      L = $urandom_range(0, 6);
      for (int i = 0; i < L * BPW; i++) pay[i] = 8'($urandom);
      run_stream(L, 3, $urandom_range(0, 5));
    end
    wr_mode = 0;
    step();

    // Asynchronous reset in the middle of PAYLOAD.
    arm();
    mon_e.addr = '0;
    mon_e.data = 16'h0201;
    exp_q.push_back(mon_e);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h01);
    step();
    send_byte(8'h02);
    repeat (3) step();
    send_byte(8'h03);
    check("pre_rst_busy", 64'(busy), 1);
    check("pre_rst_write_ptr", 64'(bus.write_ptr), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_wr_valid", 64'(bus.wr_valid), 0);
    check("arst_write_ptr", 64'(bus.write_ptr), 0);
    check("arst_wdata", 64'(bus.wdata), 0);
    check("arst_read_ptr", 64'(read_ptr), 0);
    check("arst_busy_done", 64'({busy, done}), 0);
    check("arst_errs", 64'({err_len, err_ovr, err_tmo}), 0);
    exp_q.delete();
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
